// File: rtl/imm_pkg.sv
// Shared types and field layout for the immediate packer and its loader.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10
  } err_code_t;

  // Word bit positions of each immediate fragment
  localparam int unsigned I_IMM_LSB  = 20;
  localparam int unsigned S_HI_LSB   = 25;
  localparam int unsigned S_LO_LSB   = 7;
  localparam int unsigned B_SIGN_BIT = 31;
  localparam int unsigned B_HI_LSB   = 25;
  localparam int unsigned B_LO_LSB   = 8;
  localparam int unsigned B_B11_BIT  = 7;
  localparam int unsigned J_SIGN_BIT = 31;
  localparam int unsigned J_LO_LSB   = 21;
  localparam int unsigned J_B11_BIT  = 20;
  localparam int unsigned J_HI_LSB   = 12;

  // Word bits owned by the immediate; everything else comes from the base word
  localparam logic [31:0] I_FIELD_MASK = 32'hFFF0_0000;
  localparam logic [31:0] S_FIELD_MASK = 32'hFE00_0F80;
  localparam logic [31:0] B_FIELD_MASK = 32'hFE00_0F80;
  localparam logic [31:0] J_FIELD_MASK = 32'hFFFF_F000;

  // Highest immediate bit that still carries information; above it must be sign copies
  localparam int unsigned I_SIGN_MSB = 11;
  localparam int unsigned S_SIGN_MSB = 11;
  localparam int unsigned B_SIGN_MSB = 12;
  localparam int unsigned J_SIGN_MSB = 20;

  typedef struct packed {
    imm_src_t    src;
    logic [31:0] imm;
    logic [31:0] base;
  } pack_req_t;

  typedef struct packed {
    logic [31:0] word;
    logic        range_err;
    logic        misalign;
  } pack_rsp_t;

  // True when v[31:msb] are all copies of one bit, i.e. v fits a (msb+1)-bit signed field
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] s;
    s = $signed(v) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: places a signed immediate into an instruction word
// and flags entries whose value does not fit or is not halfword aligned.
module imm_pack
  import imm_pkg::*;
(
  input  pack_req_t req,
  output pack_rsp_t rsp
);

  logic [31:0] imm;
  assign imm = req.imm;

  // Merge the scattered immediate fragments over the base word and run the checks
  always_comb begin
    rsp = '0;
    unique case (req.src)
      IMM_I: begin
        rsp.word      = (req.base & ~I_FIELD_MASK)
                      | (32'(imm[11:0]) << I_IMM_LSB);
        rsp.range_err = !fits_signed(imm, I_SIGN_MSB);
      end
      IMM_S: begin
        rsp.word      = (req.base & ~S_FIELD_MASK)
                      | (32'(imm[11:5]) << S_HI_LSB)
                      | (32'(imm[4:0])  << S_LO_LSB);
        rsp.range_err = !fits_signed(imm, S_SIGN_MSB);
      end
      IMM_B: begin
        rsp.word      = (req.base & ~B_FIELD_MASK)
                      | (32'(imm[12])   << B_SIGN_BIT)
                      | (32'(imm[10:5]) << B_HI_LSB)
                      | (32'(imm[4:1])  << B_LO_LSB)
                      | (32'(imm[11])   << B_B11_BIT);
        rsp.range_err = !fits_signed(imm, B_SIGN_MSB);
        rsp.misalign  = imm[0];
      end
      IMM_J: begin
        rsp.word      = (req.base & ~J_FIELD_MASK)
                      | (32'(imm[20])    << J_SIGN_BIT)
                      | (32'(imm[10:1])  << J_LO_LSB)
                      | (32'(imm[11])    << J_B11_BIT)
                      | (32'(imm[19:12]) << J_HI_LSB);
        rsp.range_err = !fits_signed(imm, J_SIGN_MSB);
        rsp.misalign  = imm[0];
      end
      default: rsp = '0;
    endcase
  end

endmodule

// File: rtl/imm_pack_loader.sv
// Loader: accepts immediate entries, packs them and writes one instruction
// word per two cycles into consecutive memory words, tracking entry errors.
module imm_pack_loader
  import imm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_imm_src,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  input  logic        in_last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        load_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // idx is one bit wider than needed so DEPTH=256 compares cleanly
  localparam logic [8:0] LAST_IDX = 9'(DEPTH - 1);

  state_t    state;
  logic [8:0] idx;
  logic      last_q;
  err_code_t err_code_q;
  pack_req_t req;
  pack_rsp_t rsp;
  logic      accept;
  logic      faulty;

  assign req.src  = imm_src_t'(in_imm_src);
  assign req.imm  = in_imm;
  assign req.base = in_base;

  imm_pack u_pack (
    .req (req),
    .rsp (rsp)
  );

  assign accept   = in_valid && in_ready;
  assign faulty   = rsp.range_err || rsp.misalign;
  assign err_code = err_code_q;

  // Load FSM: capture and pack on accept, strobe the write, then advance or finish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      idx        <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      load_done  <= 1'b0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      err_count  <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (accept) begin
            state     <= ST_WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + (32'(idx) << 2);
            mem_wdata <= rsp.word;
            last_q    <= in_last;
            // Faulty entries are still written; only the first error kind is kept
            if (faulty) begin
              err <= 1'b1;
              if (err_code_q == ERR_NONE)
                err_code_q <= rsp.range_err ? ERR_RANGE : ERR_MISALIGN;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            end
          end
        end
        ST_WRITE: begin
          mem_we <= 1'b0;
          idx    <= idx + 9'd1;
          if (last_q || idx == LAST_IDX) begin
            state     <= ST_DONE;
            load_done <= 1'b1;
          end else begin
            state    <= ST_LOAD;
            in_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          in_ready <= 1'b0;
        end
        default: begin
          state    <= ST_LOAD;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_pack_loader.sv
// Scoreboard bench for imm_pack_loader: directed vectors, error tracking,
// depth limit, reset during a write and randomized legal round-trips.
module tb_imm_pack_loader;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] S_BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 0, in_last = 0;
  logic [1:0]  in_imm_src = 0;
  logic [31:0] in_imm = 0, in_base = 0;
  logic        in_ready, mem_we, load_done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  logic        s_in_valid = 0;
  logic        s_in_ready, s_mem_we, s_load_done, s_err;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [1:0]  s_err_code;
  logic [7:0]  s_err_count;

  imm_pack_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm_src(in_imm_src), .in_imm(in_imm), .in_base(in_base), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_done(load_done), .err(err), .err_code(err_code), .err_count(err_count)
  );

  imm_pack_loader #(.BASE_ADDR(S_BASE), .DEPTH(4)) dut_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_imm_src(2'b00), .in_imm(32'd5), .in_base(32'h0000_0013), .in_last(1'b0),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .load_done(s_load_done), .err(s_err), .err_code(s_err_code), .err_count(s_err_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
    logic [7:0]  cnt;
    logic [1:0]  src;
    logic [31:0] imm;
    logic        legal;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ssb[$];
  int checks = 0, errors = 0;

  // reference state of the current load and the sticky error record
  int         exp_idx = 0;
  logic       m_err = 0;
  logic [1:0] m_code = 0;
  int         m_cnt = 0;

  function automatic logic [31:0] ref_pack(logic [1:0] src, logic [31:0] imm, logic [31:0] base);
    logic [31:0] w;
    w = base;
    case (src)
      2'd0: w[31:20] = imm[11:0];
      2'd1: begin w[31:25] = imm[11:5]; w[11:7] = imm[4:0]; end
      2'd2: begin w[31] = imm[12]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1]; w[7] = imm[11]; end
      default: begin w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12]; end
    endcase
    return w;
  endfunction

  function automatic logic [31:0] ref_decode(logic [1:0] src, logic [31:0] w);
    case (src)
      2'd0: return {{20{w[31]}}, w[31:20]};
      2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic ref_in_range(logic [1:0] src, logic [31:0] imm);
    int v;
    v = imm;
    case (src)
      2'd0, 2'd1: return (v >= -2048) && (v <= 2047);
      2'd2:       return (v >= -4096) && (v <= 4095);
      default:    return (v >= -1048576) && (v <= 1048575);
    endcase
  endfunction

  function automatic logic [31:0] rand_legal(int f);
    int v, lo, hi;
    case (f)
      0, 1:    begin lo = -2048;    hi = 2047;    end
      2:       begin lo = -4096;    hi = 4094;    end
      default: begin lo = -1048576; hi = 1048574; end
    endcase
    case ($urandom_range(0, 9))
      0:       v = lo;
      1:       v = hi;
      default: v = lo + int'($urandom_range(0, 32'(hi - lo)));
    endcase
    if (f >= 2) v = v & ~1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, mem_addr, BASE);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_err_code"}, 32'(err_code), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  task automatic clear_model();
    exp_idx = 0; m_err = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    sb.delete();
    reset = 1;
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    reset = 0;
    clear_model();
    #1 chk("reset_in_ready", 32'(in_ready), 1);
  endtask

  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base, input logic last);
    int   waited;
    exp_t e;
    logic rng, mis;
    waited = 0;
    @(negedge clk);
    in_imm_src = src; in_imm = imm; in_base = base; in_last = last; in_valid = 1;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
      in_valid = 0;
      return;
    end
    rng = ref_in_range(src, imm);
    mis = src[1] && imm[0];
    if (!rng || mis) begin
      if (m_code == 2'b00) m_code = !rng ? 2'b01 : 2'b10;
      m_err = 1;
      if (m_cnt < 255) m_cnt++;
    end
    e.addr  = BASE + 32'(4 * exp_idx);
    e.data  = ref_pack(src, imm, base);
    e.err   = m_err;
    e.code  = m_code;
    e.cnt   = 8'(m_cnt);
    e.src   = src;
    e.imm   = imm;
    e.legal = rng && !mis;
    sb.push_back(e);
    exp_idx++;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic expect_done();
    int n;
    n = 0;
    while (!load_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("load_done", 32'(load_done), 1);
    chk("done_in_ready", 32'(in_ready), 0);
    in_imm_src = 0; in_imm = 1; in_base = 0; in_last = 0; in_valid = 1;
    repeat (4) @(negedge clk);
    in_valid = 0;
    chk("done_hold", 32'(load_done), 1);
  endtask

  // main-DUT monitor: every write must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%h data=%h required no write", mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (mem_addr !== e.addr || mem_wdata !== e.data || err !== e.err ||
            err_code !== e.code || err_count !== e.cnt || load_done !== 1'b0) begin
          errors++;
          $display("FAIL write got addr=%h data=%h err=%0b code=%0d cnt=%0d done=%0b required addr=%h data=%h err=%0b code=%0d cnt=%0d done=0",
                   mem_addr, mem_wdata, err, err_code, err_count, load_done,
                   e.addr, e.data, e.err, e.code, e.cnt);
        end
        if (e.legal) begin
          checks++;
          if (ref_decode(e.src, mem_wdata) !== e.imm) begin
            errors++;
            $display("FAIL roundtrip src=%0d got=%h required=%h", e.src, ref_decode(e.src, mem_wdata), e.imm);
          end
        end
      end
    end
  end

  // small-DUT monitor: addresses must walk the four words from its base
  always @(negedge clk) begin
    if (!reset && s_mem_we) begin
      checks++;
      if (ssb.size() == 0) begin
        errors++;
        $display("FAIL small_unexpected_write addr=%h required no write", s_mem_addr);
      end else begin
        logic [31:0] a;
        a = ssb.pop_front();
        if (s_mem_addr !== a || s_mem_wdata !== 32'h0050_0013) begin
          errors++;
          $display("FAIL small_write got addr=%h data=%h required addr=%h data=00500013", s_mem_addr, s_mem_wdata, a);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    int s_acc, left, n;
    repeat (2) @(negedge clk);
    chk_reset_outputs("init");
    reset = 0;
    #1 chk("init_in_ready", 32'(in_ready), 1);

    // DEPTH=4 instance: five-plus offered entries, only four taken
    for (int i = 0; i < 4; i++) ssb.push_back(S_BASE + 32'(4 * i));
    @(negedge clk);
    s_in_valid = 1;
    s_acc = 0;
    for (int i = 0; i < 16; i++) begin
      if (s_in_ready) s_acc++;
      @(negedge clk);
    end
    s_in_valid = 0;
    chk("small_accepts", 32'(s_acc), 4);
    chk("small_load_done", 32'(s_load_done), 1);
    chk("small_in_ready", 32'(s_in_ready), 0);
    chk("small_sb_drained", 32'(ssb.size()), 0);

    // directed packing vectors
    send(2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 0);
    send(2'd1, 32'd8,         32'h0000_2023, 0);
    send(2'd2, -32'sd4,       32'h0000_0063, 0);
    send(2'd3, 32'h0000_0800, 32'h0000_006F, 1);
    expect_done();
    do_reset();

    // error record: RANGE first, later errors only count
    send(2'd0, 32'd2048,      32'h0000_0013, 0);
    send(2'd2, 32'd3,         32'h0000_0063, 0);
    send(2'd1, -32'sd2049,    32'hFFFF_FFFF, 0);
    send(2'd3, 32'h0010_0000, 32'h0000_006F, 0);
    send(2'd0, 32'd2047,      32'h0000_0013, 1);
    expect_done();
    do_reset();

    // MISALIGN first, then RANGE must not overwrite it
    send(2'd3, 32'd5,    32'h0000_006F, 0);
    send(2'd0, 32'd4096, 32'h0000_0013, 1);
    expect_done();
    do_reset();

    // both checks failing reports RANGE
    send(2'd2, 32'd4097, 32'h0000_0063, 1);
    expect_done();
    do_reset();

    // reset while the write strobe is up drops the write
    @(negedge clk);
    in_imm_src = 0; in_imm = 32'd2048; in_base = 32'h13; in_last = 1; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    chk("pre_reset_mem_we", 32'(mem_we), 1);
    reset = 1;
    #1 chk_reset_outputs("wreset");
    @(negedge clk);
    reset = 0;
    clear_model();
    send(2'd0, 32'd1, 32'h0000_0013, 1);
    expect_done();
    do_reset();

    // depth limit on the main instance
    for (int k = 0; k < DEPTH; k++) begin
      n = int'($urandom_range(0, 3));
      send(2'(n), rand_legal(n), $urandom, 0);
    end
    expect_done();
    do_reset();

    // randomized legal entries, 200 per format, in loads of random length
    for (int f = 0; f < 4; f++) begin
      left = 200;
      while (left > 0) begin
        n = int'($urandom_range(1, 30));
        if (n > left) n = left;
        for (int k = 0; k < n; k++) send(2'(f), rand_legal(f), $urandom, k == n - 1);
        left -= n;
        expect_done();
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
